// File: rtl/nrisc_ula_seq_if.sv
// Handshake and operand/result bundle for nrisc_ula_seq.
// master = issuing stage (control unit / testbench), slave = the ULA.
interface nrisc_ula_seq_if #(
  parameter int TAM = 32
);
  logic           ULA_in_valid;
  logic           ULA_in_ready;
  logic [TAM-1:0] ULA_A;
  logic [TAM-1:0] ULA_B;
  logic [3:0]     ULA_ctrl;
  logic           ULA_out_valid;
  logic           ULA_out_ready;
  logic [TAM-1:0] ULA_OUT;
  logic [TAM-1:0] ULA_HI;
  logic [2:0]     ULA_flags;

  modport master (
    output ULA_in_valid, ULA_A, ULA_B, ULA_ctrl, ULA_out_ready,
    input  ULA_in_ready, ULA_out_valid, ULA_OUT, ULA_HI, ULA_flags
  );

  modport slave (
    input  ULA_in_valid, ULA_A, ULA_B, ULA_ctrl, ULA_out_ready,
    output ULA_in_ready, ULA_out_valid, ULA_OUT, ULA_HI, ULA_flags
  );
endinterface

// File: rtl/nrisc_ula_seq.sv
// Multi-cycle NRISC ULA: add/sub/logic/shift/rotate plus registered result and flags.
// Iterative mul/divu (ops B/C) exist only when NRISC_ULA_MULDIV_EN is defined; otherwise they act as reserved.
module nrisc_ula_seq #(
  parameter int TAM = 32
) (
  input  logic           ULA_clk,
  input  logic           ULA_rst_n,
  nrisc_ula_seq_if.slave bus
);
  localparam int SHW = $clog2(TAM);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
  state_t state;

  assign bus.ULA_in_ready = (state == IDLE);

  logic [SHW-1:0]   amt;
  logic [TAM:0]     sum;
  logic [TAM:0]     dif;
  logic [2*TAM-1:0] wide;
  logic [TAM-1:0]   res;
  logic             c_flag;
  logic             m_flag;

  always_comb begin
    amt = bus.ULA_B[SHW-1:0];
    if ({{(32-SHW){1'b0}}, amt} >= TAM) amt = amt - SHW'(TAM);
    sum    = {1'b0, bus.ULA_A} + {1'b0, bus.ULA_B};
    dif    = {1'b0, bus.ULA_A} - {1'b0, bus.ULA_B};
    wide   = '0;
    res    = '0;
    c_flag = 1'b0;
    m_flag = 1'b0;
    case (bus.ULA_ctrl)
      4'h0: begin
        res    = sum[TAM-1:0];
        c_flag = sum[TAM];
        m_flag = sum[TAM-1] ^ ((bus.ULA_A[TAM-1] == bus.ULA_B[TAM-1]) &&
                               (sum[TAM-1] != bus.ULA_A[TAM-1]));
      end
      4'h1: begin
        res    = dif[TAM-1:0];
        c_flag = dif[TAM];
        m_flag = dif[TAM-1] ^ ((bus.ULA_A[TAM-1] != bus.ULA_B[TAM-1]) &&
                               (dif[TAM-1] != bus.ULA_A[TAM-1]));
      end
      4'h2: res = bus.ULA_A & bus.ULA_B;
      4'h3: res = ~(bus.ULA_A & bus.ULA_B);
      4'h4: res = bus.ULA_A | bus.ULA_B;
      4'h5: res = bus.ULA_A ^ bus.ULA_B;
      // Shifts run in a double-width window so the last bit shifted out lands at a fixed index
      4'h6: begin
        wide   = {bus.ULA_A, {TAM{1'b0}}} >> amt;
        res    = wide[2*TAM-1:TAM];
        c_flag = (amt != '0) && wide[TAM-1];
      end
      4'h7: begin
        wide   = $unsigned($signed({bus.ULA_A, {TAM{1'b0}}}) >>> amt);
        res    = wide[2*TAM-1:TAM];
        c_flag = (amt != '0) && wide[TAM-1];
      end
      4'h8: begin
        wide   = {{TAM{1'b0}}, bus.ULA_A} << amt;
        res    = wide[TAM-1:0];
        c_flag = (amt != '0) && wide[TAM];
      end
      4'h9: begin
        wide = {bus.ULA_A, bus.ULA_A} << amt;
        res  = wide[2*TAM-1:TAM];
      end
      4'hA: begin
        wide = {bus.ULA_A, bus.ULA_A} >> amt;
        res  = wide[TAM-1:0];
      end
      default: ;
    endcase
  end

  logic iter_op;

`ifdef NRISC_ULA_MULDIV_EN
  localparam int CW = $clog2(TAM + 1);

  logic [TAM-1:0] opnd;
  logic [TAM-1:0] acc;
  logic [TAM-1:0] mq;
  logic [TAM-1:0] acc_nxt;
  logic [TAM-1:0] mq_nxt;
  logic [CW-1:0]  count;
  logic           is_div;
  logic [TAM:0]   step;
  logic [TAM:0]   rs;

  assign iter_op = (bus.ULA_ctrl == 4'hB) || (bus.ULA_ctrl == 4'hC);

  // acc holds product high half / partial remainder, mq holds multiplier / dividend-quotient
  always_comb begin
    rs      = {acc, mq[TAM-1]};
    step    = {1'b0, acc} + {1'b0, opnd};
    acc_nxt = acc;
    mq_nxt  = mq;
    if (is_div) begin
      if (rs >= {1'b0, opnd}) begin
        acc_nxt = TAM'(rs - {1'b0, opnd});
        mq_nxt  = {mq[TAM-2:0], 1'b1};
      end else begin
        acc_nxt = rs[TAM-1:0];
        mq_nxt  = {mq[TAM-2:0], 1'b0};
      end
    end else if (mq[0]) begin
      {acc_nxt, mq_nxt} = {step, mq[TAM-1:1]};
    end else begin
      {acc_nxt, mq_nxt} = {1'b0, acc, mq[TAM-1:1]};
    end
  end
`else
  assign iter_op = 1'b0;
`endif

  always_ff @(posedge ULA_clk or negedge ULA_rst_n) begin
    if (!ULA_rst_n) begin
      state             <= IDLE;
      bus.ULA_out_valid <= 1'b0;
      bus.ULA_OUT       <= '0;
      bus.ULA_HI        <= '0;
      bus.ULA_flags     <= 3'b010;
`ifdef NRISC_ULA_MULDIV_EN
      opnd   <= '0;
      acc    <= '0;
      mq     <= '0;
      count  <= '0;
      is_div <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.ULA_in_valid && iter_op) begin
`ifdef NRISC_ULA_MULDIV_EN
            is_div <= (bus.ULA_ctrl == 4'hC);
            opnd   <= (bus.ULA_ctrl == 4'hC) ? bus.ULA_B : bus.ULA_A;
            mq     <= (bus.ULA_ctrl == 4'hC) ? bus.ULA_A : bus.ULA_B;
            acc    <= '0;
            count  <= CW'(TAM);
            state  <= EXEC;
`endif
          end else if (bus.ULA_in_valid) begin
            bus.ULA_OUT       <= res;
            bus.ULA_HI        <= '0;
            bus.ULA_flags     <= {m_flag, (res == '0), c_flag};
            bus.ULA_out_valid <= 1'b1;
            state             <= DONE;
          end
        end
`ifdef NRISC_ULA_MULDIV_EN
        EXEC: begin
          acc   <= acc_nxt;
          mq    <= mq_nxt;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            bus.ULA_OUT       <= mq_nxt;
            bus.ULA_HI        <= acc_nxt;
            bus.ULA_flags     <= {1'b0, (mq_nxt == '0), (is_div && (opnd == '0))};
            bus.ULA_out_valid <= 1'b1;
            state             <= DONE;
          end
        end
`endif
        DONE: begin
          if (bus.ULA_out_ready) begin
            bus.ULA_out_valid <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/nrisc_ula_seq.md
Name: nrisc_ula_seq

Overview:
- Parametrised, multi-cycle successor to the NRISC combinational ULA.
- Keeps the full add/sub/logic/shift/rotate set, generalised to any width.
- Adds iterative unsigned multiply and divide, a valid/ready handshake on both sides, and registered result and flags.
- Sits between the register-file read stage and writeback; the control unit stalls on ULA_in_ready.

Parameters:
TAM, 32, datapath width in bits; integer, at least 4 (power of two not required)
SHW, $clog2(TAM), shift-amount width; localparam, not overridable

Ports:
ULA_clk  in  1  clock; all state updates on rising edge
ULA_rst_n  in  1  asynchronous active-low reset
ULA_in_valid  in  1  operands and command valid
ULA_in_ready  out  1  block can accept an operation
ULA_A  in  TAM  operand A
ULA_B  in  TAM  operand B
ULA_ctrl  in  4  operation select
ULA_out_valid  out  1  result and flags valid
ULA_out_ready  in  1  consumer accepts result
ULA_OUT  out  TAM  result (mul low half / div quotient)
ULA_HI  out  TAM  mul high half / div remainder; 0 for other ops
ULA_flags  out  3  {minus, zero, carry}

Behaviour:
- Clock and reset: one clock, ULA_clk. Reset ULA_rst_n is asynchronous, active-low.
- Reset values: state IDLE; ULA_out_valid=0; ULA_OUT=0; ULA_HI=0; ULA_flags=3'b010.
- ULA_in_ready = (state==IDLE). Inputs are ignored while reset is asserted.
- States and transitions:
  - IDLE: on in_valid, capture A/B/ctrl. Single-cycle ops go to DONE; ops 0xB/0xC go to EXEC with counter=TAM.
  - EXEC: one iteration per cycle; counter decrements; at counter==1 write results and go to DONE.
  - DONE: out_valid=1; outputs held stable until out_ready=1, then go to IDLE.
- Latency and throughput:
  - Single-cycle ops: out_valid one cycle after acceptance.
  - Mul/div: out_valid TAM+1 cycles after acceptance.
  - Maximum throughput is one op per 2 cycles; no accept in the same cycle as result handoff.
- ctrl encoding:
  - 0 add; 1 sub (A-B); 2 and; 3 nand; 4 or; 5 xor.
  - 6 shr logical; 7 shr arithmetic; 8 shl; 9 rotl; A rotr.
  - B mul unsigned; C divu.
  - D-F reserved: result 0, HI 0, latency 1.
- Shift and rotate amount is B[SHW-1:0] mod TAM; amount 0 returns A unchanged.
- Flag rules:
  - carry, add: true carry-out of bit TAM-1.
  - carry, sub: 1 iff A<B unsigned (borrow). B==0 gives carry=0.
  - carry, shl: last bit shifted out of bit TAM-1. shr/sar: last bit shifted out of bit 0. Amount 0 gives carry=0.
  - carry, all other ops: 0.
  - minus: signed overflow-corrected sign for add/sub, i.e. (result[TAM-1] XOR V) where V is signed overflow. 0 for all other ops.
  - zero: ULA_OUT==0 (low half only for mul).
- Multiply: shift-add, one bit of B per cycle; 2*TAM-bit product split into OUT (low) and HI (high).
- Divide: restoring, one quotient bit per cycle.
- Divide by zero: OUT = all ones, HI = A, carry=1, latency unchanged.
- Reset mid-EXEC or mid-DONE: abort immediately, return to reset values; the pending result is discarded.

Optional Feature:
- Macro: NRISC_ULA_MULDIV_EN.
- Defined: ops B/C behave as above, with EXEC state and iteration registers.
- Undefined: EXEC logic and counter are not synthesised; ops B/C behave as reserved (OUT=0, HI=0, flags 3'b010, latency 1).

Test Plan:
- TAM=32, add A=0xFFFFFFFF, B=1 -> OUT=0, flags=3'b011, out_valid exactly 1 cycle after accept.
- Sub A=3, B=5 -> OUT=0xFFFFFFFE, minus=1, carry=1. Then sub A=0x80000000, B=1 -> OUT=0x7FFFFFFF, minus=1 (overflow-corrected).
- rotl A=0x80000001, B=4 -> OUT=0x00000018. Then shl A=0x80000000, B=1 -> OUT=0, flags=3'b011. Then rotr with B=32 -> OUT=A.
- Mul A=0xFFFFFFFF, B=2 -> OUT=0xFFFFFFFE, HI=1, out_valid at cycle TAM+1=33. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- divu A=100, B=7 -> OUT=14, HI=2. divu B=0, A=9 -> OUT=0xFFFFFFFF, HI=9, carry=1.
- Assert ULA_rst_n low at EXEC cycle 10 of a mul -> out_valid=0 and flags=3'b010 asynchronously; after release, in_ready=1 and a new add completes correctly. Repeat with TAM=8 and with NRISC_ULA_MULDIV_EN undefined (mul returns 0).
